fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0080, SHALL be the exception redirect target.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_out  input  32  current PC register value; also the fetch address.
REQ-005 pc_in  output  32  next PC value driven to the PC register.
REQ-006 pcWrite  output  1  PC register load enable.
REQ-007 imem_req  output  1  instruction-memory read request at address pc_out.
REQ-008 imem_ack  input  1  instruction-memory data valid; completes the request.
REQ-009 if_valid  output  1  fetched word valid for IF/ID capture this cycle.
REQ-010 hazard_stall  input  1  decode cannot accept a new instruction.
REQ-011 exc  input  1  exception redirect to EXC_VECTOR.
REQ-012 br_taken, br_target  input  1, 32  taken-branch redirect and its target.
REQ-013 jmp, jmp_target  input  1, 32  jump redirect and its target.
REQ-014 stall_cnt  output  32  PC-hold cycle counter; present only under REQ-032.

Function
REQ-015 Redirect SHALL be exc | br_taken | jmp; target priority exc > br_taken > jmp; target bits [1:0] forced to 0.
REQ-016 Sequential next PC SHALL be pc_out + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-017 States SHALL be READY, WAIT, DRAIN, HOLD; all outputs combinational from state and inputs, except the pending-target register.
REQ-018 READY, redirect: imem_req=0, pcWrite=1, pc_in=target, if_valid=0; stay READY.
REQ-019 READY, hazard_stall and no redirect: imem_req=0, pcWrite=0; stay READY.
REQ-020 READY otherwise: imem_req=1; imem_ack same cycle -> if_valid=1, pcWrite=1, pc_in=pc_out+4, stay READY (zero-wait fetch); no ack -> WAIT.
REQ-021 Once imem_req is asserted it SHALL stay high with pc_out unchanged until imem_ack; pcWrite SHALL be 0 while a request is outstanding without ack.
REQ-022 WAIT, ack and redirect same cycle: if_valid=0, pcWrite=1, pc_in=target, -> READY.
REQ-023 WAIT, ack and hazard_stall: if_valid=0, pcWrite=0, -> HOLD.
REQ-024 WAIT, ack otherwise: if_valid=1, pcWrite=1, pc_in=pc_out+4, -> READY.
REQ-025 WAIT, redirect without ack: latch target into pending register, -> DRAIN.
REQ-026 DRAIN: imem_req=1 until ack; a new redirect overwrites the pending target; on ack if_valid=0, pcWrite=1, pc_in=pending (or current redirect target if asserted that cycle), -> READY.
REQ-027 HOLD: imem_req=0; redirect -> pcWrite=1, pc_in=target, if_valid=0, -> READY; else hazard_stall high -> hold, outputs 0; else if_valid=1, pcWrite=1, pc_in=pc_out+4, -> READY.
REQ-028 imem_ack while no request is outstanding SHALL be ignored.
REQ-029 if_valid and pcWrite-with-redirect SHALL never assert in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force state READY, pending register 0, stall_cnt 0; while low, pc_in=0, pcWrite=0, imem_req=0, if_valid=0.
REQ-031 Reset mid-request SHALL abandon the request; a late ack is ignored per REQ-028.

Configuration
REQ-032 Macro FETCH_PERF_EN defined: stall_cnt port exists, increments by 1 each cycle with pcWrite=0 after reset release, saturating at 32'hFFFF_FFFF; undefined: port and counter absent, all other behaviour identical.

Verification
REQ-033 Reset release, pc_out=0, ack tied high -> pc_in 4, 8, 12 on consecutive cycles, if_valid=1 every cycle.
REQ-034 pc_out=32'h100, ack delayed 3 cycles -> imem_req high 4 cycles, pcWrite=0 for 3, then if_valid=1, pc_in=32'h104.
REQ-035 In WAIT, br_taken=1 with br_target=32'h203 for one cycle, ack 2 cycles later -> if_valid=0 on ack, pc_in=32'h200.
REQ-036 exc, br_taken, jmp all high in READY -> pc_in=32'h80, pcWrite=1, imem_req=0.
REQ-037 Ack during hazard_stall held 2 cycles -> HOLD, if_valid=1 on first cycle stall low; pc_out=32'hFFFF_FFFC -> pc_in=0.
REQ-038 With FETCH_PERF_EN, the REQ-034 scenario -> stall_cnt=3; rst_n pulsed low mid-WAIT -> all outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer driving the PC register and instruction-memory handshake
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_out              : current PC, also the fetch address
//   pc_in, pcWrite      : next PC value and PC load enable
//   imem_req, imem_ack  : instruction-memory read request / data valid
//   if_valid            : fetched word valid for IF/ID capture
//   hazard_stall        : decode cannot accept a new instruction
//   exc, br_taken, jmp  : redirects (priority exc > br_taken > jmp) with their targets
//   stall_cnt           : PC-hold cycle counter, present only when FETCH_PERF_EN is defined
module fetch_seq #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_out,
    output logic [31:0] pc_in,
    output logic        pcWrite,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        if_valid,
    input  logic        hazard_stall,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
`ifdef FETCH_PERF_EN
    input  logic [31:0] jmp_target,
    output logic [31:0] stall_cnt
`else
    input  logic [31:0] jmp_target
`endif
);
    typedef enum logic [1:0] {READY, WAIT, DRAIN, HOLD} state_t;
    state_t state, nxt;
    logic [31:0] pend, pend_d, npc, tgt, seq;
    logic redir, req, we, vld;
    assign redir = exc | br_taken | jmp;
    assign tgt = (exc ? EXC_VECTOR : br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;
    assign seq = pc_out + 32'd4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READY;
            pend <= 32'h0;
        end else begin
            state <= nxt;
            pend <= pend_d;
        end
    end
    // A redirect without ack leaves the request in flight; DRAIN waits for that
    // ack, discards the word, and then loads the remembered target.
    always_comb begin
        nxt = state;
        pend_d = pend;
        req = 1'b0;
        we = 1'b0;
        vld = 1'b0;
        npc = 32'h0;
        case (state)
            READY: begin
                if (redir) begin
                    we = 1'b1;
                    npc = tgt;
                end else if (!hazard_stall) begin
                    req = 1'b1;
                    if (imem_ack) begin
                        vld = 1'b1;
                        we = 1'b1;
                        npc = seq;
                    end else begin
                        nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (imem_ack) begin
                    if (redir) begin
                        we = 1'b1;
                        npc = tgt;
                        nxt = READY;
                    end else if (hazard_stall) begin
                        nxt = HOLD;
                    end else begin
                        vld = 1'b1;
                        we = 1'b1;
                        npc = seq;
                        nxt = READY;
                    end
                end else if (redir) begin
                    pend_d = tgt;
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (imem_ack) begin
                    we = 1'b1;
                    npc = redir ? tgt : pend;
                    nxt = READY;
                end else if (redir) begin
                    pend_d = tgt;
                end
            end
            HOLD: begin
                if (redir) begin
                    we = 1'b1;
                    npc = tgt;
                    nxt = READY;
                end else if (!hazard_stall) begin
                    vld = 1'b1;
                    we = 1'b1;
                    npc = seq;
                    nxt = READY;
                end
            end
            default: nxt = READY;
        endcase
    end
    // Outputs are forced low for the whole time reset is asserted, not just after the next edge.
    assign imem_req = rst_n & req;
    assign pcWrite = rst_n & we;
    assign if_valid = rst_n & vld;
    assign pc_in = rst_n ? npc : 32'h0;
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 32'h0;
        else if (!we && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq
module tb_fetch_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] pc_out = 32'h0;
    logic [31:0] pc_in;
    logic pcWrite, imem_req, if_valid;
    logic imem_ack = 1'b0;
    logic hazard_stall = 1'b0;
    logic exc = 1'b0;
    logic br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic jmp = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    int total = 0;
    int bad = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    fetch_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_out(pc_out),
        .pc_in(pc_in),
        .pcWrite(pcWrite),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .if_valid(if_valid),
        .hazard_stall(hazard_stall),
        .exc(exc),
        .br_taken(br_taken),
        .br_target(br_target),
        .jmp(jmp),
`ifdef FETCH_PERF_EN
        .jmp_target(jmp_target),
        .stall_cnt(stall_cnt)
`else
        .jmp_target(jmp_target)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        imem_ack = 1'b0;
        hazard_stall = 1'b0;
        exc = 1'b0;
        br_taken = 1'b0;
        jmp = 1'b0;
        br_target = 32'h0;
        jmp_target = 32'h0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc_out = 32'h1234;
        exc = 1'b1;
        imem_ack = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl actual=%b required=000", {imem_req, pcWrite, if_valid});
        end
        total++;
        if (pc_in !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc actual=%h required=00000000", pc_in);
        end
        tick();
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        do_reset();
        pc_out = 32'h0;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 32'd4 * (i + 1);
            #1;
            total++;
            if ({imem_req, pcWrite, if_valid} !== 3'b111) begin
                bad++;
                $display("FAIL zw_ctl[%0d] actual=%b required=111", i, {imem_req, pcWrite, if_valid});
            end
            total++;
            if (pc_in !== exp) begin
                bad++;
                $display("FAIL zw_pc[%0d] actual=%h required=%h", i, pc_in, exp);
            end
            tick();
            pc_out = exp;
        end
    endtask

    task automatic test_wait_ack();
        do_reset();
        pc_out = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({imem_req, pcWrite, if_valid} !== 3'b100) begin
                bad++;
                $display("FAIL wait_ctl[%0d] actual=%b required=100", i, {imem_req, pcWrite, if_valid});
            end
            tick();
        end
        imem_ack = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b111) begin
            bad++;
            $display("FAIL wait_ack_ctl actual=%b required=111", {imem_req, pcWrite, if_valid});
        end
        total++;
        if (pc_in !== 32'h104) begin
            bad++;
            $display("FAIL wait_ack_pc actual=%h required=00000104", pc_in);
        end
        tick();
`ifdef FETCH_PERF_EN
        total++;
        if (stall_cnt !== 32'd3) begin
            bad++;
            $display("FAIL stall_cnt actual=%0d required=3", stall_cnt);
        end
`endif
        imem_ack = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        pc_out = 32'h200;
        tick();
        br_taken = 1'b1;
        br_target = 32'h203;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b100) begin
            bad++;
            $display("FAIL drain_enter actual=%b required=100", {imem_req, pcWrite, if_valid});
        end
        tick();
        br_taken = 1'b0;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b100) begin
            bad++;
            $display("FAIL drain_hold actual=%b required=100", {imem_req, pcWrite, if_valid});
        end
        tick();
        imem_ack = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b110) begin
            bad++;
            $display("FAIL drain_ack_ctl actual=%b required=110", {imem_req, pcWrite, if_valid});
        end
        total++;
        if (pc_in !== 32'h200) begin
            bad++;
            $display("FAIL drain_ack_pc actual=%h required=00000200", pc_in);
        end
        tick();
        do_reset();
        pc_out = 32'h300;
        tick();
        jmp = 1'b1;
        jmp_target = 32'h30C;
        tick();
        jmp = 1'b0;
        br_taken = 1'b1;
        br_target = 32'h311;
        tick();
        br_taken = 1'b0;
        imem_ack = 1'b1;
        #1;
        total++;
        if (pc_in !== 32'h310 || pcWrite !== 1'b1 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_overwrite actual=%h/%b%b required=00000310/10", pc_in, pcWrite, if_valid);
        end
        tick();
        clear_in();
    endtask

    task automatic test_priority();
        do_reset();
        pc_out = 32'h40;
        exc = 1'b1;
        br_taken = 1'b1;
        jmp = 1'b1;
        br_target = 32'h400;
        jmp_target = 32'h503;
        #1;
        total++;
        if (pc_in !== 32'h80 || {imem_req, pcWrite, if_valid} !== 3'b010) begin
            bad++;
            $display("FAIL prio_exc actual=%h/%b required=00000080/010", pc_in, {imem_req, pcWrite, if_valid});
        end
        exc = 1'b0;
        #1;
        total++;
        if (pc_in !== 32'h400) begin
            bad++;
            $display("FAIL prio_br actual=%h required=00000400", pc_in);
        end
        br_taken = 1'b0;
        #1;
        total++;
        if (pc_in !== 32'h500) begin
            bad++;
            $display("FAIL prio_jmp actual=%h required=00000500", pc_in);
        end
        tick();
        clear_in();
        tick();
        imem_ack = 1'b1;
        exc = 1'b1;
        #1;
        total++;
        if (pc_in !== 32'h80 || {imem_req, pcWrite, if_valid} !== 3'b110) begin
            bad++;
            $display("FAIL wait_ack_redir actual=%h/%b required=00000080/110", pc_in, {imem_req, pcWrite, if_valid});
        end
        tick();
        clear_in();
    endtask

    task automatic test_hold();
        do_reset();
        pc_out = 32'hFFFF_FFFC;
        hazard_stall = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL ready_stall actual=%b required=000", {imem_req, pcWrite, if_valid});
        end
        hazard_stall = 1'b0;
        tick();
        imem_ack = 1'b1;
        hazard_stall = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b100) begin
            bad++;
            $display("FAIL hold_enter actual=%b required=100", {imem_req, pcWrite, if_valid});
        end
        tick();
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL hold_stay actual=%b required=000", {imem_req, pcWrite, if_valid});
        end
        tick();
        imem_ack = 1'b0;
        hazard_stall = 1'b0;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b011 || pc_in !== 32'h0) begin
            bad++;
            $display("FAIL hold_release actual=%b/%h required=011/00000000", {imem_req, pcWrite, if_valid}, pc_in);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc_out = 32'h600;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b000 || pc_in !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset actual=%b/%h required=000/00000000", {imem_req, pcWrite, if_valid}, pc_in);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (stall_cnt !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_cnt actual=%0d required=0", stall_cnt);
        end
`endif
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1;
        hazard_stall = 1'b1;
        #1;
        total++;
        if ({imem_req, pcWrite, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL late_ack actual=%b required=000", {imem_req, pcWrite, if_valid});
        end
        tick();
        clear_in();
    endtask

    initial begin
        tick();
        test_reset();
        test_zero_wait();
        test_wait_ack();
        test_drain();
        test_priority();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
